// File: rtl/pad_cfg_seq_pkg.sv
// -----------------------------------------------------------------------------
// pad_cfg_seq_pkg
// Shared types and constants for the pad attribute sequencer.
//   pad_attr_t : per-pad attribute word driven to the padring
//   state_e    : sequencer FSM states (3-bit encoding)
//   SETTLE_*   : legal range of the settle-time parameter
// -----------------------------------------------------------------------------
package pad_cfg_seq_pkg;

    // Attribute layout matches the padring wrapper attribute inputs.
    typedef struct packed {
        logic       invert;
        logic       virt_od_en;
        logic       pull_en;
        logic       pull_select;
        logic       keeper_en;
        logic       schmitt_en;
        logic       od_en;
        logic [1:0] slew_rate;
        logic [3:0] drive_strength;
    } pad_attr_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_APPLY   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 255;
    localparam int CNT_W      = 8;

    // Counter preload for one phase of SettleCycles cycles.
    function automatic logic [CNT_W-1:0] settle_load(input int settle_cycles);
        return CNT_W'(settle_cycles - 1);
    endfunction

endpackage

// File: rtl/pad_cfg_seq_if.sv
// -----------------------------------------------------------------------------
// pad_cfg_seq_if
// Request/completion bus of the pad attribute sequencer.
//   req_valid / req_ready : request handshake (accept when both high)
//   req_pad / req_attr    : target pad index and new attribute
//   done / err            : one-cycle completion pulse, err for a bad index
//   busy                  : sequencer not idle
// master = requester, slave = sequencer.
// -----------------------------------------------------------------------------
interface pad_cfg_seq_if
    import pad_cfg_seq_pkg::*;
#(
    parameter int PadIdxW = 6
);
    logic               req_valid;
    logic               req_ready;
    logic [PadIdxW-1:0] req_pad;
    pad_attr_t          req_attr;
    logic               done;
    logic               err;
    logic               busy;

    modport master (
        output req_valid, req_pad, req_attr,
        input  req_ready, done, err, busy
    );

    modport slave (
        input  req_valid, req_pad, req_attr,
        output req_ready, done, err, busy
    );
endinterface

// File: rtl/pad_cfg_seq_fsm.sv
// -----------------------------------------------------------------------------
// pad_cfg_seq_fsm
// Sequencer control: Idle -> Quiesce -> Apply -> Settle -> Done -> Idle.
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   bus            : request bus (slave side)
//   o_apply        : one-cycle strobe to write o_attr into pad o_idx
//   o_idx, o_attr  : captured request
//   o_force_set    : acceptance of a valid request (set force for bus.req_pad)
//   o_force_clr    : release the force mask (Done state)
// -----------------------------------------------------------------------------
module pad_cfg_seq_fsm
    import pad_cfg_seq_pkg::*;
#(
    parameter int NMioPads     = 47,
    parameter int SettleCycles = 4,
    parameter int PadIdxW      = $clog2(NMioPads)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    pad_cfg_seq_if.slave       bus,
    output logic               o_apply,
    output logic [PadIdxW-1:0] o_idx,
    output pad_attr_t          o_attr,
    output logic               o_force_set,
    output logic               o_force_clr
);

    localparam logic [CNT_W-1:0] CntLoad = settle_load(SettleCycles);

    state_e             r_state,    w_state_next;
    logic [CNT_W-1:0]   r_cnt,      w_cnt_next;
    logic [PadIdxW-1:0] r_idx,      w_idx_next;
    pad_attr_t          r_attr,     w_attr_next;
    logic               r_err,      w_err_next;
    logic               w_idx_ok;

    assign w_idx_ok = (32'(bus.req_pad) < 32'(NMioPads));

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_attr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_attr  <= w_attr_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_attr_next  = r_attr;
        w_err_next   = r_err;
        o_apply      = 1'b0;
        o_force_set  = 1'b0;
        o_force_clr  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_idx_next  = bus.req_pad;
                    w_attr_next = bus.req_attr;
                    if (w_idx_ok) begin
                        w_state_next = ST_QUIESCE;
                        w_cnt_next   = CntLoad;
                        w_err_next   = 1'b0;
                        o_force_set  = 1'b1;
                    end else begin
                        // Bad index: report straight away, touch no pad.
                        w_state_next = ST_DONE;
                        w_err_next   = 1'b1;
                    end
                end
            end
            ST_QUIESCE: begin
                if (r_cnt == '0) w_state_next = ST_APPLY;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            ST_APPLY: begin
                o_apply      = 1'b1;
                w_cnt_next   = CntLoad;
                w_state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (r_cnt == '0) w_state_next = ST_DONE;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            ST_DONE: begin
                o_force_clr  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.err       = (r_state == ST_DONE) & r_err;

    assign o_idx  = r_idx;
    assign o_attr = r_attr;

endmodule

// File: rtl/pad_cfg_seq.sv
// -----------------------------------------------------------------------------
// pad_cfg_seq
// Sequences runtime pad attribute changes so a pad is never reconfigured
// while driven: its output enable is forced low for SettleCycles before and
// after the attribute write.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   bus           : request bus (slave side)
//   mio_oe_i      : output enables from the pinmux
//   mio_oe_o      : gated output enables to the padring
//   mio_attr_o    : registered per-pad attributes to the padring
// -----------------------------------------------------------------------------
module pad_cfg_seq
    import pad_cfg_seq_pkg::*;
#(
    parameter int NMioPads     = 47,
    parameter int SettleCycles = 4,
    parameter int PadIdxW      = $clog2(NMioPads)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    pad_cfg_seq_if.slave               bus,
    input  logic      [NMioPads-1:0]   mio_oe_i,
    output logic      [NMioPads-1:0]   mio_oe_o,
    output pad_attr_t [NMioPads-1:0]   mio_attr_o
);

    if (SettleCycles < SETTLE_MIN || SettleCycles > SETTLE_MAX) begin : g_bad_settle
        $error("pad_cfg_seq: SettleCycles=%0d outside %0d..%0d",
               SettleCycles, SETTLE_MIN, SETTLE_MAX);
    end

    logic               w_apply;
    logic [PadIdxW-1:0] w_idx;
    pad_attr_t          w_attr;
    logic               w_force_set;
    logic               w_force_clr;
    logic [NMioPads-1:0] w_force_onehot;

    logic      [NMioPads-1:0] r_force;
    pad_attr_t [NMioPads-1:0] r_attr_q;

    pad_cfg_seq_fsm #(
        .NMioPads     (NMioPads),
        .SettleCycles (SettleCycles),
        .PadIdxW      (PadIdxW)
    ) u_fsm (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .bus         (bus),
        .o_apply     (w_apply),
        .o_idx       (w_idx),
        .o_attr      (w_attr),
        .o_force_set (w_force_set),
        .o_force_clr (w_force_clr)
    );

    // Force set only fires for an in-range index, so the shift never overflows.
    assign w_force_onehot = {{(NMioPads-1){1'b0}}, 1'b1} << bus.req_pad;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_force <= '0;
        end else if (w_force_clr) begin
            r_force <= '0;
        end else if (w_force_set) begin
            r_force <= w_force_onehot;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: this register array is reset on purpose: the padring must see
        // defined attributes straight out of reset, so it cannot map to RAM.
        if (!rst_ni) begin
            r_attr_q <= '0;
        end else if (w_apply) begin
            r_attr_q[w_idx] <= w_attr;
        end
    end

    assign mio_oe_o   = mio_oe_i & ~r_force;
    assign mio_attr_o = r_attr_q;

endmodule
